// File: rtl/scan_controller_if.sv
// Host-side command/status bundle for scan_controller.
// stop_on_hit exists only when STOP_ON_HIT_EN is defined.
interface scan_controller_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
`ifdef STOP_ON_HIT_EN
  logic              stop_on_hit;
`endif
  logic              busy_o;
  logic              done_o;
  logic              aborted_o;
  logic [CNT_W-1:0]  match_cnt_o;
  logic              hit_found_o;
  logic [ADDR_W-1:0] first_hit_addr_o;

`ifdef STOP_ON_HIT_EN
  modport master (
    output start, abort, base_addr, length, stop_on_hit,
    input  busy_o, done_o, aborted_o, match_cnt_o, hit_found_o, first_hit_addr_o
  );
  modport slave (
    input  start, abort, base_addr, length, stop_on_hit,
    output busy_o, done_o, aborted_o, match_cnt_o, hit_found_o, first_hit_addr_o
  );
`else
  modport master (
    output start, abort, base_addr, length,
    input  busy_o, done_o, aborted_o, match_cnt_o, hit_found_o, first_hit_addr_o
  );
  modport slave (
    input  start, abort, base_addr, length,
    output busy_o, done_o, aborted_o, match_cnt_o, hit_found_o, first_hit_addr_o
  );
`endif
endinterface

// File: rtl/scan_controller.sv
// Sequences a signature scan over a 1-bit sample memory feeding a bit-serial detector.
// Optional macro STOP_ON_HIT_EN: a latched stop_on_hit ends the scan at the first counted hit.
module scan_controller #(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 1,
  parameter int DET_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  scan_controller_if.slave  host,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_en_o,
  input  logic              mem_bit_i,
  output logic              det_bit_o,
  output logic              det_bit_valid_o,
  output logic              det_rst_n_o,
  input  logic              det_hit_i
);
  localparam int P  = MEM_LAT + DET_LAT;
  localparam int DW = $clog2(P);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;

  logic [ADDR_W:0]   remaining;
  logic [DW-1:0]     drain_cnt;
  logic [P-1:0]      pipe_v;
  logic [ADDR_W-1:0] pipe_a [P];
  logic              busy, done, aborted, hit_found;
  logic [CNT_W-1:0]  match_cnt;
  logic [ADDR_W-1:0] first_hit_addr;
  logic [ADDR_W:0]   len_clamped;
  logic              hit, stop_hit;

  assign len_clamped = host.length[ADDR_W] ? {1'b1, ADDR_W'(0)} : host.length;
  // Slot P-1 is the hit window of the address issued P cycles earlier.
  assign hit = pipe_v[P-1] & det_hit_i;

`ifdef STOP_ON_HIT_EN
  logic stop_q;
  assign stop_hit = hit & stop_q;
`else
  assign stop_hit = 1'b0;
`endif

  assign det_bit_valid_o = pipe_v[MEM_LAT-1];
  assign det_bit_o       = pipe_v[MEM_LAT-1] & mem_bit_i;

  assign host.busy_o           = busy;
  assign host.done_o           = done;
  assign host.aborted_o        = aborted;
  assign host.match_cnt_o      = match_cnt;
  assign host.hit_found_o      = hit_found;
  assign host.first_hit_addr_o = first_hit_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      remaining      <= '0;
      drain_cnt      <= '0;
      pipe_v         <= '0;
      for (int unsigned i = 0; i < P; i++) pipe_a[i] <= '0;
      mem_addr_o     <= '0;
      mem_en_o       <= 1'b0;
      det_rst_n_o    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      match_cnt      <= '0;
      hit_found      <= 1'b0;
      first_hit_addr <= '0;
`ifdef STOP_ON_HIT_EN
      stop_q         <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      pipe_v  <= {pipe_v[P-2:0], mem_en_o};
      pipe_a[0] <= mem_addr_o;
      for (int unsigned i = 1; i < P; i++) pipe_a[i] <= pipe_a[i-1];

      if (hit) begin
        if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
        if (!hit_found) begin
          hit_found      <= 1'b1;
          first_hit_addr <= pipe_a[P-1];
        end
      end

      case (state)
        IDLE: begin
          if (host.start && !host.abort) begin
            mem_addr_o     <= host.base_addr;
            remaining      <= len_clamped;
            match_cnt      <= '0;
            hit_found      <= 1'b0;
            first_hit_addr <= '0;
`ifdef STOP_ON_HIT_EN
            stop_q         <= host.stop_on_hit;
`endif
            if (len_clamped == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= ISSUE;
              mem_en_o    <= 1'b1;
              busy        <= 1'b1;
              det_rst_n_o <= 1'b1;
            end
          end
        end
        ISSUE, DRAIN: begin
          // Abort and stop-on-hit both discard in-flight bits by clearing the valid pipe.
          if (host.abort) begin
            state       <= IDLE;
            aborted     <= 1'b1;
            mem_en_o    <= 1'b0;
            busy        <= 1'b0;
            det_rst_n_o <= 1'b0;
            pipe_v      <= '0;
          end else if (stop_hit) begin
            state       <= DONE;
            done        <= 1'b1;
            mem_en_o    <= 1'b0;
            busy        <= 1'b0;
            det_rst_n_o <= 1'b0;
            pipe_v      <= '0;
          end else if (state == ISSUE) begin
            mem_addr_o <= mem_addr_o + ADDR_W'(1);
            remaining  <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) begin
              state     <= DRAIN;
              mem_en_o  <= 1'b0;
              drain_cnt <= DW'(P-1);
            end
          end else if (drain_cnt == '0) begin
            state       <= DONE;
            done        <= 1'b1;
            busy        <= 1'b0;
            det_rst_n_o <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scan_controller.sv
// Scoreboard bench for scan_controller: memory and a "1011" detector model drive the DUT,
// expected done/aborted results are queued at issue time and checked when the pulse appears.
`timescale 1ns/1ps
module tb_scan_controller;
  localparam int ADDR_W  = 12;
  localparam int MEM_LAT = 1;
  localparam int DET_LAT = 2;
  localparam int CNT_W   = 4;
  localparam int LAT     = MEM_LAT + DET_LAT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_controller_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) sif ();

  logic [ADDR_W-1:0] mem_addr;
  logic mem_en, det_bit, det_bit_valid, det_rst_n, det_hit;
  logic mem_bit = 1'b0;

  scan_controller #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .DET_LAT(DET_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .host(sif.slave),
    .mem_addr_o(mem_addr), .mem_en_o(mem_en), .mem_bit_i(mem_bit),
    .det_bit_o(det_bit), .det_bit_valid_o(det_bit_valid), .det_rst_n_o(det_rst_n),
    .det_hit_i(det_hit)
  );

  logic mem [4096];
  always @(posedge clk) if (mem_en) mem_bit <= mem[mem_addr];

  // Detector model: flags "1011" with two cycles of latency.
  logic [2:0] det_sh = 3'b0;
  logic det_m1 = 1'b0, det_out = 1'b0, force_hit = 1'b0;
  always @(posedge clk) begin
    if (!det_rst_n) begin
      det_sh <= 3'b0; det_m1 <= 1'b0; det_out <= 1'b0;
    end else begin
      det_out <= det_m1;
      det_m1  <= det_bit_valid && ({det_sh, det_bit} == 4'b1011);
      if (det_bit_valid) det_sh <= {det_sh[1:0], det_bit};
    end
  end
  assign det_hit = det_out | force_hit;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit abrt; int cyc; int cnt; bit hit; int addr; } exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (sif.done_o || sif.aborted_o)) begin
      if (sb.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_pulse: done=%0d aborted=%0d at cycle %0d, none expected",
                 sif.done_o, sif.aborted_o, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_is_abort", {31'b0, sif.aborted_o}, {31'b0, e.abrt});
        check("pulse_cycle", cyc, e.cyc);
        check("match_cnt", {28'b0, sif.match_cnt_o}, e.cnt);
        check("hit_found", {31'b0, sif.hit_found_o}, {31'b0, e.hit});
        check("first_hit_addr", {20'b0, sif.first_hit_addr_o}, e.addr);
      end
    end
  end

  logic [ADDR_W-1:0] seen_addr [4];

  task automatic run_scan(input int base, input int len, input int done_off, input int exp_cnt,
                          input bit exp_hit, input int exp_addr, input int exp_issues,
                          input int exp_busy, input string tag);
    int e;
    int issues = 0, busy = 0;
    bit seen = 1'b0;
    @(negedge clk);
    sif.start = 1'b1; sif.base_addr = base[ADDR_W-1:0]; sif.length = len[ADDR_W:0];
    e = cyc + 1;
    sb.push_back('{1'b0, e + done_off, exp_cnt, exp_hit, exp_addr});
    @(negedge clk);
    sif.start = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      if (mem_en) begin
        if (issues < 4) seen_addr[issues] = mem_addr;
        issues++;
      end
      if (sif.busy_o) busy++;
      if (sif.done_o || sif.aborted_o) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      compared++; mismatched++;
      $display("FAIL %s_timeout: no done/aborted pulse within budget", tag);
    end
    check({tag, "_issues"}, issues, exp_issues);
    check({tag, "_busy_cycles"}, busy, exp_busy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e;
    sif.start = 1'b0; sif.abort = 1'b0; sif.base_addr = '0; sif.length = '0;
`ifdef STOP_ON_HIT_EN
    sif.stop_on_hit = 1'b0;
`endif
    for (int i = 0; i < 4096; i++) mem[i] = 1'b0;
    mem[16'h010] = 1'b1; mem[16'h011] = 1'b0; mem[16'h012] = 1'b1;
    mem[16'h013] = 1'b1; mem[16'h014] = 1'b1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'b0, sif.busy_o}, 0);
    check("rst_done", {31'b0, sif.done_o}, 0);
    check("rst_aborted", {31'b0, sif.aborted_o}, 0);
    check("rst_mem_en", {31'b0, mem_en}, 0);
    check("rst_mem_addr", {20'b0, mem_addr}, 0);
    check("rst_det_rst_n", {31'b0, det_rst_n}, 0);
    check("rst_det_valid", {31'b0, det_bit_valid}, 0);
    check("rst_match_cnt", {28'b0, sif.match_cnt_o}, 0);
    check("rst_hit_found", {31'b0, sif.hit_found_o}, 0);
    check("rst_first_hit", {20'b0, sif.first_hit_addr_o}, 0);

    run_scan(12'h010, 16, 16 + LAT, 1, 1'b1, 12'h013, 16, 16 + LAT, "basic");

    // Hits while idle or in DONE must not count.
    force_hit = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_force_cnt", {28'b0, sif.match_cnt_o}, 1);
    check("idle_force_addr", {20'b0, sif.first_hit_addr_o}, 12'h013);
    run_scan(12'h050, 0, 0, 0, 1'b0, 0, 0, 0, "len0");
    repeat (3) @(negedge clk);
    check("done_force_cnt", {28'b0, sif.match_cnt_o}, 0);
    force_hit = 1'b0;

    run_scan(12'hFFE, 4, 4 + LAT, 0, 1'b0, 0, 4, 4 + LAT, "wrap");
    check("wrap_addr0", {20'b0, seen_addr[0]}, 12'hFFE);
    check("wrap_addr1", {20'b0, seen_addr[1]}, 12'hFFF);
    check("wrap_addr2", {20'b0, seen_addr[2]}, 12'h000);
    check("wrap_addr3", {20'b0, seen_addr[3]}, 12'h001);

    run_scan(0, 13'h1FFF, 4096 + LAT, 1, 1'b1, 12'h013, 4096, 4096 + LAT, "clamp");

    // Abort on the third issue cycle; a start while busy is ignored.
    @(negedge clk);
    sif.start = 1'b1; sif.base_addr = 12'h020; sif.length = 13'd16;
    e = cyc + 1;
    sb.push_back('{1'b1, e + 3, 0, 1'b0, 0});
    @(negedge clk); sif.start = 1'b0;
    @(negedge clk); sif.start = 1'b1; sif.base_addr = 12'h010;
    @(negedge clk); sif.start = 1'b0; sif.abort = 1'b1;
    @(negedge clk); sif.abort = 1'b0;
    check("abort_det_rst_n", {31'b0, det_rst_n}, 0);
    check("abort_mem_en", {31'b0, mem_en}, 0);
    check("abort_busy", {31'b0, sif.busy_o}, 0);
    check("abort_det_valid", {31'b0, det_bit_valid}, 0);
    repeat (10) @(negedge clk);
    check("abort_idle_busy", {31'b0, sif.busy_o}, 0);

    // Abort after the hit has been counted keeps the result.
    @(negedge clk);
    sif.start = 1'b1; sif.base_addr = 12'h010; sif.length = 13'd16;
    e = cyc + 1;
    sb.push_back('{1'b1, e + 9, 1, 1'b1, 12'h013});
    @(negedge clk); sif.start = 1'b0;
    repeat (8) @(negedge clk);
    sif.abort = 1'b1;
    @(negedge clk); sif.abort = 1'b0;
    repeat (5) @(negedge clk);

    // start together with abort in IDLE does nothing; results hold.
    sif.start = 1'b1; sif.abort = 1'b1; sif.base_addr = 12'h200; sif.length = 13'd8;
    @(negedge clk); sif.start = 1'b0; sif.abort = 1'b0;
    check("start_abort_busy", {31'b0, sif.busy_o}, 0);
    repeat (4) @(negedge clk);
    check("start_abort_idle", {31'b0, sif.busy_o}, 0);
    check("hold_match_cnt", {28'b0, sif.match_cnt_o}, 1);
    check("hold_hit_found", {31'b0, sif.hit_found_o}, 1);

    // Reset mid-scan discards the scan silently.
    sif.start = 1'b1; sif.base_addr = 12'h010; sif.length = 13'd16;
    @(negedge clk); sif.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_busy", {31'b0, sif.busy_o}, 0);
    check("midrst_match_cnt", {28'b0, sif.match_cnt_o}, 0);
    repeat (25) @(negedge clk);

    force_hit = 1'b1;
    run_scan(12'h100, 40, 40 + LAT, 15, 1'b1, 12'h100, 40, 40 + LAT, "saturate");
    force_hit = 1'b0;

`ifdef STOP_ON_HIT_EN
    mem[16'h030] = 1'b1; mem[16'h031] = 1'b0; mem[16'h032] = 1'b1; mem[16'h033] = 1'b1;
    sif.stop_on_hit = 1'b0;
    run_scan(12'h010, 48, 48 + LAT, 2, 1'b1, 12'h013, 48, 48 + LAT, "nostop");
    sif.stop_on_hit = 1'b1;
    run_scan(12'h010, 48, 7, 1, 1'b1, 12'h013, 7, 7, "stop");
    sif.stop_on_hit = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("pending_expectations", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/scan_controller.md
Name: scan_controller

Overview:
- Sequences a signature scan over the 1-bit-wide sample block memory that feeds the bit-serial pattern detector FSM.
- Accepts a start/base/length command, issues one memory address per cycle and aligns memory read latency and detector latency.
- Holds the detector in reset between scans, counts detector hits inside the scan window and records the first hit address.
- Reports done/busy to the host-side control logic.

Parameters:
ADDR_W, 12, memory address width (depth 2^ADDR_W)
MEM_LAT, 1, memory read latency in cycles (addr to douta), >=1
DET_LAT, 2, cycles from a bit at detector input to its detect output, >=1
CNT_W, 16, match counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  command strobe, sampled only in IDLE
abort  in  1  terminate scan in progress
base_addr  in  ADDR_W  first bit address of scan
length  in  ADDR_W+1  bits to scan; values >2^ADDR_W clamp to 2^ADDR_W
mem_addr_o  out  ADDR_W  memory read address
mem_en_o  out  1  memory read enable
mem_bit_i  in  1  memory douta
det_bit_o  out  1  bit forwarded to detector seq input
det_bit_valid_o  out  1  det_bit_o carries a scan bit
det_rst_n_o  out  1  active-low detector reset
det_hit_i  in  1  detector detect output
busy_o  out  1  scan in progress
done_o  out  1  one-cycle pulse, scan completed normally
aborted_o  out  1  one-cycle pulse, scan aborted
match_cnt_o  out  CNT_W  qualified hits in last/current scan
hit_found_o  out  1  at least one qualified hit
first_hit_addr_o  out  ADDR_W  address of bit that produced first hit

Behaviour:
- Reset values: all outputs 0 except det_rst_n_o=0; state IDLE; pipelines cleared. Reset mid-scan discards the scan with no done_o or aborted_o.
- States:
  - IDLE: det_rst_n_o=0. start=1 latches base/clamped length, clears match_cnt_o/hit_found_o/first_hit_addr_o and goes to ISSUE next cycle. If the clamped length is 0, go to DONE instead.
  - ISSUE: mem_en_o=1, mem_addr_o=current address, det_rst_n_o=1. Address increments mod 2^ADDR_W (0xFFF wraps to 0x000). After the length-th issue, go to DRAIN.
  - DRAIN: mem_en_o=0. Wait exactly MEM_LAT+DET_LAT cycles, then go to DONE.
  - DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in ISSUE and DRAIN.
- Valid/address pipeline:
  - An address issued at cycle T appears on det_bit_o with det_bit_valid_o=1 at T+MEM_LAT (det_bit_o = mem_bit_i, combinational pass).
  - Its hit window is cycle T+MEM_LAT+DET_LAT.
  - det_bit_o=0 when not valid.
- Hit qualification: det_hit_i counts only in a cycle whose pipeline slot is valid. On a counted hit:
  - match_cnt_o increments, saturating at 2^CNT_W-1.
  - On the first counted hit only: hit_found_o=1 and first_hit_addr_o = pipeline address.
  - Hits outside the window, including detector flush garbage, are ignored.
- Results hold until the next accepted start.
- start while busy is ignored. start and abort together in IDLE: abort wins, start ignored, no pulse.
- abort in ISSUE/DRAIN:
  - Next cycle is IDLE, with aborted_o=1 for one cycle and mem_en_o=0.
  - Pipeline valids clear; det_rst_n_o=0.
  - Counts gathered so far are retained.
- abort in DONE is ignored (done_o still pulses).
- Total scan latency: start accepted at T0 gives done_o at T0+1+L+MEM_LAT+DET_LAT, for L>=1.

Optional Feature:
STOP_ON_HIT_EN
- Defined:
  - Adds input port stop_on_hit (1 bit, latched with start).
  - When the latched value is 1, the first counted hit ends the scan: ISSUE stops immediately, in-flight bits are discarded (valids cleared), and the next cycle enters DONE (done_o pulse, match_cnt_o=1).
- Undefined: port absent; every scan runs full length.

Test Plan:
- Memory holds 1,0,1,1,1 at 0x010..0x014, rest 0. start, base=0x010, length=16 → done_o at T0+20; match_cnt_o=1; first_hit_addr_o equals the pipeline-reported address; busy_o high T0+1..T0+19.
- length=0 → done_o at T0+1; mem_en_o never asserted; match_cnt_o=0, hit_found_o=0.
- base=0xFFE, length=4 → mem_addr_o sequence 0xFFE,0xFFF,0x000,0x001; length=0x1FFF clamps to 4096 issues.
- abort asserted 3 cycles into ISSUE → aborted_o pulses once, no done_o, det_rst_n_o=0 next cycle; start pulse during busy has no effect.
- Force det_hit_i=1 during IDLE/DRAIN-tail/DONE → match_cnt_o unchanged. Force continuous hits with CNT_W=4 and length=40 → saturates at 15.
- STOP_ON_HIT_EN with stop_on_hit=1 and two signatures in range → done_o right after first hit, match_cnt_o=1; with stop_on_hit=0 → match_cnt_o=2.
